// File: rtl/int_sched.sv
// int_sched: interrupt scheduler for the single-cycle CPU datapath.
// Latches four request lines into pending bits, selects one winner by fixed
// priority (line 1 highest) among the masked, globally-enabled candidates and
// drives a one-cycle one-hot issue pulse (ie1..ie4). In-service levels are
// tracked so only strictly higher priority may preempt a running ISR.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   irq        raw requests, bit0 = line 1 (highest) .. bit3 = line 4
//   take_ok    control unit at an instruction boundary
//   we_mask    write mask register from mask_in
//   mask_in    new mask value, 1 = line enabled
//   gie_set    set global enable
//   gie_clr    clear global enable (wins over gie_set)
//   reti       return-from-interrupt pulse
//   ie         one-hot issue pulse, registered
//   pending    pending latches
//   in_service active ISR levels
//   mask       mask register
//   gie        global enable
//   err_reti   pulse on reti with no active level
module int_sched #(
   parameter logic [3:0] EDGE_MASK = 4'b1111,
   parameter bit         NEST_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] irq,
   input  logic       take_ok,
   input  logic       we_mask,
   input  logic [3:0] mask_in,
   input  logic       gie_set,
   input  logic       gie_clr,
   input  logic       reti,
   output logic [3:0] ie,
   output logic [3:0] pending,
   output logic [3:0] in_service,
   output logic [3:0] mask,
   output logic       gie,
   output logic       err_reti
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BLANK
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] irq_q;
   logic [3:0] set_v;
   logic [3:0] cand;
   logic [3:0] win;
   logic [3:0] isv_low;
   logic       win_ok;
   logic [3:0] ie_nxt;
   logic [3:0] iss_clr;
   logic [3:0] ret_clr;

   always_comb begin
      set_v   = (irq & ~irq_q & EDGE_MASK) | (irq & ~EDGE_MASK);
      cand    = pending & mask & {4{gie}};
      // x & -x isolates the lowest set bit, i.e. the highest-priority line
      win     = cand & (~cand + 4'd1);
      isv_low = in_service & (~in_service + 4'd1);
      // both are one-hot, so a smaller value means a higher-priority line
      if (NEST_EN)
         win_ok = (cand != '0) && ((in_service == '0) || (win < isv_low));
      else
         win_ok = (cand != '0) && (in_service == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // The winner is frozen into ie on entry to ISSUE; ie then serves as the
   // clear and in-service set vector for the ISSUE cycle.
   always_comb begin
      state_nxt = state;
      ie_nxt    = '0;
      case (state)
         IDLE: begin
            if (take_ok && win_ok) begin
               state_nxt = ISSUE;
               ie_nxt    = win;
            end
         end
         ISSUE:   state_nxt = BLANK;
         BLANK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      iss_clr = (state == ISSUE) ? ie : '0;
      ret_clr = reti ? isv_low : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_q      <= '0;
         ie         <= '0;
         pending    <= '0;
         in_service <= '0;
         mask       <= '0;
         gie        <= 1'b0;
         err_reti   <= 1'b0;
      end else begin
         irq_q      <= irq;
         ie         <= ie_nxt;
         pending    <= (pending & ~iss_clr) | set_v;
         in_service <= (in_service & ~ret_clr) | iss_clr;
         err_reti   <= reti && (in_service == '0);
         if (we_mask)
            mask <= mask_in;
         if (gie_clr)
            gie <= 1'b0;
         else if (gie_set)
            gie <= 1'b1;
      end
   end

endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: directed bench for int_sched. Stimulus queues each expected
// issue pulse / err_reti pulse with the cycle it should appear in; a monitor
// compares every pulse the DUT presents against the queue head.
module tb_int_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic       take_ok;
   logic       we_mask;
   logic [3:0] mask_in;
   logic       gie_set;
   logic       gie_clr;
   logic       reti;
   logic [3:0] ie;
   logic [3:0] pending;
   logic [3:0] in_service;
   logic [3:0] mask;
   logic       gie;
   logic       err_reti;

   typedef struct {
      logic [3:0] ie;
      logic       err;
      int         cyc;
   } ev_t;

   ev_t exp_q[$];
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;

   int_sched #(
      .EDGE_MASK(4'b1111),
      .NEST_EN  (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .irq       (irq),
      .take_ok   (take_ok),
      .we_mask   (we_mask),
      .mask_in   (mask_in),
      .gie_set   (gie_set),
      .gie_clr   (gie_clr),
      .reti      (reti),
      .ie        (ie),
      .pending   (pending),
      .in_service(in_service),
      .mask      (mask),
      .gie       (gie),
      .err_reti  (err_reti)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ie(input logic [3:0] v, input int at);
      ev_t e;
      e.ie  = v;
      e.err = 1'b0;
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic expect_err(input int at);
      ev_t e;
      e.ie  = 4'b0000;
      e.err = 1'b1;
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic pulse_reti();
      reti = 1'b1;
      step(1);
      reti = 1'b0;
   endtask

   // Monitor: every pulse on ie or err_reti must match the queue head.
   always @(negedge clk) begin
      ev_t e;
      if (ie !== 4'b0000 || err_reti !== 1'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'({err_reti, ie}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_value", 32'({err_reti, ie}), 32'({e.err, e.ie}));
            check("pulse_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      int c;
      reset   = 1'b0;
      irq     = '0;
      take_ok = 1'b0;
      we_mask = 1'b0;
      mask_in = '0;
      gie_set = 1'b0;
      gie_clr = 1'b0;
      reti    = 1'b0;
      step(2);
      check("rst_ie", 32'(ie), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_in_service", 32'(in_service), 32'd0);
      check("rst_mask", 32'(mask), 32'd0);
      check("rst_gie", 32'(gie), 32'd0);
      check("rst_err_reti", 32'(err_reti), 32'd0);
      reset = 1'b1;

      step(1);
      we_mask = 1'b1; mask_in = 4'b1111; gie_set = 1'b1; take_ok = 1'b1;
      step(1);
      we_mask = 1'b0; gie_set = 1'b0;
      step(1);
      check("setup_mask", 32'(mask), 32'hF);
      check("setup_gie", 32'(gie), 32'd1);

      // single edge on line 3
      c = cyc; irq = 4'b0100; expect_ie(4'b0100, c + 2);
      step(1);
      check("t1_pending", 32'(pending), 32'h4);
      step(2);
      check("t1_in_service", 32'(in_service), 32'h4);
      check("t1_pending_clr", 32'(pending), 32'h0);
      irq = '0;
      step(1);
      pulse_reti();
      check("t1_reti", 32'(in_service), 32'h0);
      step(2);

      // two simultaneous edges; lower priority waits for reti
      c = cyc; irq = 4'b1010; expect_ie(4'b0010, c + 2);
      step(1);
      check("t2_pending_both", 32'(pending), 32'hA);
      irq = '0;
      step(6);
      check("t2_pending_blocked", 32'(pending), 32'h8);
      check("t2_in_service", 32'(in_service), 32'h2);
      c = cyc; expect_ie(4'b1000, c + 2);
      pulse_reti();
      check("t2_reti", 32'(in_service), 32'h0);
      step(3);
      check("t2_in_service_l4", 32'(in_service), 32'h8);
      check("t2_pending_clr", 32'(pending), 32'h0);

      // nesting: line 1 preempts line 4
      c = cyc; irq = 4'b0001; expect_ie(4'b0001, c + 2);
      step(1);
      irq = '0;
      step(2);
      check("t3_nested", 32'(in_service), 32'h9);
      pulse_reti();
      check("t3_reti1", 32'(in_service), 32'h8);
      pulse_reti();
      check("t3_reti2", 32'(in_service), 32'h0);
      step(2);

      // masked line stays pending until unmasked
      we_mask = 1'b1; mask_in = 4'b1110;
      step(1);
      we_mask = 1'b0; irq = 4'b0001;
      step(1);
      irq = '0;
      step(3);
      check("t4_mask", 32'(mask), 32'hE);
      check("t4_pending_masked", 32'(pending), 32'h1);
      check("t4_no_service", 32'(in_service), 32'h0);
      c = cyc; we_mask = 1'b1; mask_in = 4'b1111; expect_ie(4'b0001, c + 2);
      step(1);
      we_mask = 1'b0;
      step(3);
      check("t4_in_service", 32'(in_service), 32'h1);
      check("t4_pending_clr", 32'(pending), 32'h0);
      pulse_reti();
      check("t4_reti", 32'(in_service), 32'h0);
      step(2);

      // reti with nothing in service
      c = cyc; expect_err(c + 1);
      pulse_reti();
      step(1);
      check("t5_in_service", 32'(in_service), 32'h0);
      check("t5_pending", 32'(pending), 32'h0);

      // take_ok low holds IDLE while pending accumulates
      take_ok = 1'b0; irq = 4'b0010;
      step(1);
      irq = '0;
      step(4);
      check("t6_pending_held", 32'(pending), 32'h2);
      c = cyc; take_ok = 1'b1; expect_ie(4'b0010, c + 1);
      step(3);
      check("t6_in_service", 32'(in_service), 32'h2);
      check("t6_pending_clr", 32'(pending), 32'h0);
      pulse_reti();
      check("t6_reti", 32'(in_service), 32'h0);
      step(2);

      // gie set+clr together clears; then reset lands mid-ISSUE
      gie_set = 1'b1; gie_clr = 1'b1;
      step(1);
      gie_set = 1'b0; gie_clr = 1'b0;
      check("t7_gie_clr_wins", 32'(gie), 32'd0);
      irq = 4'b0100;
      step(1);
      irq = '0;
      step(3);
      check("t7_pending_nogie", 32'(pending), 32'h4);
      c = cyc; gie_set = 1'b1; expect_ie(4'b0100, c + 2);
      step(1);
      gie_set = 1'b0;
      check("t7_gie_set", 32'(gie), 32'd1);
      step(1);
      #1;
      check("t7_ie_in_issue", 32'(ie), 32'h4);
      reset = 1'b0;
      #1;
      check("t7_rst_ie", 32'(ie), 32'd0);
      check("t7_rst_pending", 32'(pending), 32'd0);
      check("t7_rst_in_service", 32'(in_service), 32'd0);
      check("t7_rst_mask", 32'(mask), 32'd0);
      check("t7_rst_gie", 32'(gie), 32'd0);
      check("t7_rst_err", 32'(err_reti), 32'd0);
      step(1);
      reset = 1'b1;
      step(3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
